// File: rtl/lpc_stream_write_master.sv
// Sample-stream sink: buffers decoded LPC samples and writes them as consecutive
// 16-bit words over an Avalon-MM write master, one armed transfer at a time.
module lpc_stream_write_master #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       d_in,
  input  logic              v,
  input  logic              d_in_clk,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       length,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [15:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [31:0]        r_accept_cnt;
  logic               r_overflow;
  logic               r_avm_write;
  logic [ADDR_W-1:0]  r_avm_address;
  logic [15:0]        r_avm_writedata;

  logic               w_arm, w_active, w_complete, w_load, w_fifo_empty;
  logic               w_strobe, w_room, w_keep, w_drop, w_take_fifo, w_bypass, w_push;
  logic [PTR_W:0]     w_occ;

  assign w_arm        = (r_state == S_IDLE) && start;
  assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_complete   = r_avm_write && !avm_waitrequest;
  assign w_load       = w_active && (!r_avm_write || w_complete);
  assign w_fifo_empty = (r_count == '0);
  assign w_strobe     = (r_state == S_RUN) && d_in_clk && v;

  // The word on the bus still occupies a slot until its write completes, so a
  // completing write frees room for a sample arriving in the same cycle.
  assign w_occ       = r_count + (PTR_W + 1)'(r_avm_write);
  assign w_room      = (w_occ < (PTR_W + 1)'(FIFO_DEPTH)) || w_complete;
  assign w_keep      = w_strobe && w_room;
  assign w_drop      = w_strobe && !w_room;
  assign w_take_fifo = w_load && !w_fifo_empty;
  assign w_bypass    = w_load && w_fifo_empty && w_keep;
  assign w_push      = w_keep && !w_bypass;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= d_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = (length == 32'd0) ? S_DONE : S_RUN;
      S_RUN:   if (w_strobe && (r_accept_cnt == 32'd1)) w_state_next = S_DRAIN;
      S_DRAIN: if (w_fifo_empty && !r_avm_write) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_accept_cnt <= '0;
      r_overflow   <= 1'b0;
    end else if (w_arm) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_accept_cnt <= length;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push)      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_take_fifo) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_take_fifo})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_strobe) r_accept_cnt <= r_accept_cnt - 32'd1;
      if (w_drop)   r_overflow   <= 1'b1;
    end
  end

  // A sample arriving while nothing is queued goes straight to the bus register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_avm_write     <= 1'b0;
      r_avm_address   <= '0;
      r_avm_writedata <= '0;
    end else begin
      if (w_arm) begin
        r_avm_address <= base_addr;
      end else if (w_complete) begin
        r_avm_address <= r_avm_address + ADDR_W'(2);
      end
      if (w_take_fifo) begin
        r_avm_writedata <= r_mem[r_rd_ptr];
        r_avm_write     <= 1'b1;
      end else if (w_bypass) begin
        r_avm_writedata <= d_in;
        r_avm_write     <= 1'b1;
      end else if (w_complete) begin
        r_avm_write     <= 1'b0;
      end
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign overflow       = r_overflow;
  assign avm_address    = r_avm_address;
  assign avm_write      = r_avm_write;
  assign avm_writedata  = r_avm_writedata;
  assign avm_byteenable = 2'b11;

endmodule

// File: tb/tb_lpc_stream_write_master.sv
// Bench for lpc_stream_write_master: directed scenarios plus random transfers,
// checked against a bounded-queue reference model of the sample path.
module tb_lpc_stream_write_master;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] d_in = '0;
  logic        v = 1'b0;
  logic        d_in_clk = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] length = '0;
  logic        busy, done, overflow;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;

  always #5 clk = ~clk;

  lpc_stream_write_master #(.FIFO_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .v(v), .d_in_clk(d_in_clk),
    .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .overflow(overflow),
    .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: samples accepted but not yet written, in order, capacity DEPTH.
  logic [15:0] q[$];
  int          remaining = 0;
  logic [31:0] exp_addr = '0;
  logic [31:0] len_m = '0;
  bit          busy_m = 0, ovf_m = 0, pending_m = 0, done_now = 0, chk_en = 0;
  int          dropped_m = 0, xfer_writes = 0, done_cnt = 0;

  always @(negedge clk) begin
    bit has, comp, done_next, was_busy;
    if (chk_en) begin
      has = (q.size() > 0);
      was_busy = busy_m;
      done_next = 0;
      check_eq("avm_write", {31'd0, avm_write}, {31'd0, has});
      if (has) begin
        check_eq("avm_address", avm_address, exp_addr);
        check_eq("avm_writedata", {16'd0, avm_writedata}, {16'd0, q[0]});
        check_eq("avm_byteenable", {30'd0, avm_byteenable}, 32'd3);
      end
      check_eq("done", {31'd0, done}, {31'd0, done_now});
      check_eq("busy", {31'd0, busy}, {31'd0, busy_m});
      check_eq("overflow", {31'd0, overflow}, {31'd0, ovf_m});
      if (reset) begin
        q.delete();
        remaining = 0; busy_m = 0; ovf_m = 0; pending_m = 0; done_now = 0;
        dropped_m = 0; xfer_writes = 0;
      end else begin
        comp = has && !avm_waitrequest;
        if (pending_m && !has) begin
          done_next = 1;
          pending_m = 0;
        end
        if (remaining > 0 && d_in_clk && v) begin
          remaining--;
          if (q.size() < DEPTH || comp) q.push_back(d_in);
          else begin
            ovf_m = 1;
            dropped_m++;
          end
          if (remaining == 0) pending_m = 1;
        end
        if (comp) begin
          void'(q.pop_front());
          exp_addr = exp_addr + 32'd2;
          xfer_writes++;
        end
        if (done_now) begin
          check_eq("writes_at_done", xfer_writes, len_m - dropped_m);
          done_cnt++;
          busy_m = 0;
        end
        if (!was_busy && start) begin
          remaining = int'(length);
          len_m = length;
          exp_addr = base_addr;
          ovf_m = 0; busy_m = 1; xfer_writes = 0; dropped_m = 0;
          if (length == 0) done_next = 1;
        end
        done_now = done_next;
      end
    end
  end

  // Slave behaviour: 0 ready, 1 stalled, 2 random, 3 three stall cycles per write.
  int wr_mode = 0;
  int stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (wr_mode)
      0: avm_waitrequest = 1'b0;
      1: avm_waitrequest = 1'b1;
      2: avm_waitrequest = ($urandom % 3 == 0);
      default: begin
        if (avm_write && stall_cnt < 3) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          avm_waitrequest = 1'b0;
          stall_cnt = 0;
        end
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] l);
    base_addr = b;
    length = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] dat, input logic vv);
    d_in = dat;
    v = vv;
    d_in_clk = 1'b1;
    tick();
    d_in_clk = 1'b0;
    v = 1'b0;
  endtask

  task automatic wait_done(input int base_cnt, input int budget);
    int k = 0;
    while (done_cnt == base_cnt && k < budget) begin
      tick();
      k++;
    end
    check_eq("done_seen", {31'd0, done_cnt != base_cnt}, 32'd1);
    tick();
  endtask

  logic [15:0] basic [4] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};

  initial begin
    int c;
    int k;
    tick();
    tick();
    chk_en = 1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    check_eq("rst_avm_write", {31'd0, avm_write}, 32'd0);
    check_eq("rst_avm_address", avm_address, 32'd0);
    reset = 1'b0;
    tick();

    // Basic transfer, then the same with three stall cycles per write.
    for (int pass = 0; pass < 2; pass++) begin
      wr_mode = (pass == 0) ? 0 : 3;
      c = done_cnt;
      do_start(32'h1000, 32'd4);
      for (int i = 0; i < 4; i++) begin
        repeat (4) tick();
        strobe(basic[i], 1'b1);
      end
      wait_done(c, 200);
      check_eq(pass == 0 ? "basic_writes" : "stall_writes", xfer_writes, 32'd4);
      check_eq("after_busy", {31'd0, busy}, 32'd0);
      check_eq("after_overflow", {31'd0, overflow}, 32'd0);
    end

    // Invalid strobes and a second start while running are ignored.
    wr_mode = 0;
    c = done_cnt;
    do_start(32'h3000, 32'd3);
    strobe(16'h1111, 1'b0);
    do_start(32'h5000, 32'd9);
    strobe(16'h2222, 1'b0);
    for (int i = 0; i < 3; i++) strobe(16'h3000 + 16'(i), 1'b1);
    wait_done(c, 100);
    check_eq("ignored_writes", xfer_writes, 32'd3);

    // Empty transfer.
    c = done_cnt;
    do_start(32'h4000, 32'd0);
    check_eq("empty_done", {31'd0, done}, 32'd1);
    tick();
    check_eq("empty_idle", {31'd0, busy}, 32'd0);
    check_eq("empty_writes", xfer_writes, 32'd0);

    // Overflow: slave stalled while six samples arrive back to back.
    wr_mode = 1;
    c = done_cnt;
    do_start(32'h6000, 32'd6);
    for (int i = 0; i < 6; i++) strobe(16'hA000 + 16'(i), 1'b1);
    tick();
    check_eq("ovf_flag", {31'd0, overflow}, 32'd1);
    wr_mode = 0;
    wait_done(c, 100);
    check_eq("ovf_writes", xfer_writes, 32'd4);

    // Reset after two of four writes, then a fresh transfer.
    c = done_cnt;
    do_start(32'h1000, 32'd4);
    k = 0;
    while (xfer_writes < 2 && k < 100) begin
      if (k % 5 == 4) strobe(16'h0100 + 16'(k), 1'b1);
      else tick();
      k++;
    end
    check_eq("midrst_progress", {31'd0, xfer_writes >= 2}, 32'd1);
    reset = 1'b1;
    tick();
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_avm_write", {31'd0, avm_write}, 32'd0);
    check_eq("midrst_avm_address", avm_address, 32'd0);
    check_eq("midrst_avm_writedata", {16'd0, avm_writedata}, 32'd0);
    reset = 1'b0;
    tick();
    c = done_cnt;
    do_start(32'h2000, 32'd4);
    for (int i = 0; i < 4; i++) strobe(16'h2000 + 16'(i), 1'b1);
    wait_done(c, 100);
    check_eq("midrst_new_writes", xfer_writes, 32'd4);

    // Random transfers, including ones that wrap the address space.
    wr_mode = 2;
    for (int t = 0; t < 25; t++) begin
      logic [31:0] b;
      b = (t % 5 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFE);
      c = done_cnt;
      do_start(b, 32'($urandom_range(1, 12)));
      k = 0;
      while (done_cnt == c && k < 600) begin
        d_in = 16'($urandom);
        d_in_clk = ($urandom % 3 == 0);
        v = ($urandom % 5 != 0);
        start = ($urandom % 16 == 0);
        base_addr = $urandom & 32'hFFFF_FFFE;
        tick();
        k++;
      end
      d_in_clk = 1'b0;
      v = 1'b0;
      start = 1'b0;
      check_eq("rand_done_seen", {31'd0, done_cnt != c}, 32'd1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
